mc_control: RTL

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_control_if.sv | 30 +++
 rtl/mc_decode.sv | 46 ++++
 rtl/mc_control.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, select and ALU codes for the multicycle controller
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL,
        CL_ADDI, CL_ORI, CL_LUI, CL_ILL
    } iclass_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    localparam logic [5:0] FUN_SLL  = 6'b000000;
    localparam logic [5:0] FUN_SRL  = 6'b000010;
    localparam logic [5:0] FUN_SRA  = 6'b000011;
    localparam logic [5:0] FUN_ADD  = 6'b100000;
    localparam logic [5:0] FUN_ADDU = 6'b100001;
    localparam logic [5:0] FUN_SUB  = 6'b100010;
    localparam logic [5:0] FUN_SUBU = 6'b100011;
    localparam logic [5:0] FUN_AND  = 6'b100100;
    localparam logic [5:0] FUN_OR   = 6'b100101;
    localparam logic [5:0] FUN_XOR  = 6'b100110;
    localparam logic [5:0] FUN_NOR  = 6'b100111;
    localparam logic [5:0] FUN_SLT  = 6'b101010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_SLT = 5'd6;
    localparam logic [4:0] ALU_SLL = 5'd7;
    localparam logic [4:0] ALU_SRL = 5'd8;
    localparam logic [4:0] ALU_SRA = 5'd9;
    localparam logic [4:0] ALU_LUI = 5'd10;

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - controller <-> datapath signal bundle
interface mc_control_if #(
    parameter int ALUF_W = 5
);
    logic [5:0]        op;
    logic [5:0]        fun;
    logic              zero;
    logic              mem_ready;
    logic              PCWr, IRWr, MemRd, MemWr, RegWr;
    logic              RegDst, MentoReg, Extop, ALUSrcA, Link;
    logic [1:0]        ALUSrcB;
    logic [1:0]        PCSrc;
    logic [ALUF_W-1:0] aluf;
    logic [2:0]        state;
    logic              illegal;

    modport master (
        input  op, fun, zero, mem_ready,
        output PCWr, IRWr, MemRd, MemWr, RegWr,
        output RegDst, MentoReg, Extop, ALUSrcA, Link,
        output ALUSrcB, PCSrc, aluf, state, illegal
    );

    modport slave (
        output op, fun, zero, mem_ready,
        input  PCWr, IRWr, MemRd, MemWr, RegWr,
        input  RegDst, MentoReg, Extop, ALUSrcA, Link,
        input  ALUSrcB, PCSrc, aluf, state, illegal
    );
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/fun to instruction class and ALU function
module mc_decode
    import mc_pkg::*;
#(
    parameter int                ALUF_W     = 5,
    parameter logic [ALUF_W-1:0] OP_ALU_ADD = 5'b00000
) (
    input  logic [5:0]        op,
    input  logic [5:0]        fun,
    output iclass_t           iclass,
    output logic [ALUF_W-1:0] aluf
);

    always_comb begin
        iclass = CL_ILL;
        aluf   = OP_ALU_ADD;
        case (op)
            OPC_RTYPE: begin
                iclass = CL_R;
                case (fun)
                    FUN_SUB, FUN_SUBU: aluf = ALUF_W'(ALU_SUB);
                    FUN_AND:           aluf = ALUF_W'(ALU_AND);
                    FUN_OR:            aluf = ALUF_W'(ALU_OR);
                    FUN_XOR:           aluf = ALUF_W'(ALU_XOR);
                    FUN_NOR:           aluf = ALUF_W'(ALU_NOR);
                    FUN_SLT:           aluf = ALUF_W'(ALU_SLT);
                    FUN_SLL:           aluf = ALUF_W'(ALU_SLL);
                    FUN_SRL:           aluf = ALUF_W'(ALU_SRL);
                    FUN_SRA:           aluf = ALUF_W'(ALU_SRA);
                    default:           aluf = OP_ALU_ADD;
                endcase
            end
            OPC_LW:   iclass = CL_LW;
            OPC_SW:   iclass = CL_SW;
            OPC_BEQ:  begin iclass = CL_BEQ; aluf = ALUF_W'(ALU_SUB); end
            OPC_BNE:  begin iclass = CL_BNE; aluf = ALUF_W'(ALU_SUB); end
            OPC_J:    iclass = CL_J;
            OPC_JAL:  iclass = CL_JAL;
            OPC_ADDI: iclass = CL_ADDI;
            OPC_ORI:  begin iclass = CL_ORI; aluf = ALUF_W'(ALU_OR); end
            OPC_LUI:  begin iclass = CL_LUI; aluf = ALUF_W'(ALU_LUI); end
            default:  iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle CPU control FSM (IF/ID/EX/MEM/WB)
module mc_control
    import mc_pkg::*;
#(
    parameter int                ALUF_W     = 5,
    parameter logic [ALUF_W-1:0] OP_ALU_ADD = 5'b00000
) (
    input  logic           clk,
    input  logic           rst,
    mc_control_if.master   bus
);

    state_t            state_r, state_next;
    logic              run;
    iclass_t           iclass;
    logic [ALUF_W-1:0] dec_aluf;

    logic              pcwr, irwr, memrd, memwr, regwr;
    logic              regdst, memtoreg, extop, srca, link, illegal;
    logic [1:0]        srcb, pcsrc;
    logic [ALUF_W-1:0] aluf;

    mc_decode #(.ALUF_W(ALUF_W), .OP_ALU_ADD(OP_ALU_ADD)) u_decode (
        .op     (bus.op),
        .fun    (bus.fun),
        .iclass (iclass),
        .aluf   (dec_aluf)
    );

    // run holds every output low until the first edge after reset, and its
    // async clear is what kills an in-flight store the moment rst rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IF;
            run     <= 1'b0;
        end else begin
            state_r <= state_next;
            run     <= 1'b1;
        end
    end

    always_comb begin
        state_next = S_IF;
        pcwr = 1'b0; irwr = 1'b0; memrd = 1'b0; memwr = 1'b0; regwr = 1'b0;
        regdst = 1'b0; memtoreg = 1'b0; extop = 1'b0; srca = 1'b0; link = 1'b0;
        illegal = 1'b0;
        srcb  = SRCB_REG;
        pcsrc = PCS_ALU;
        aluf  = '0;
        if (run) begin
            case (state_r)
                S_IF: begin
                    memrd = 1'b1;
                    srcb  = SRCB_FOUR;
                    aluf  = OP_ALU_ADD;
                    if (bus.mem_ready) begin
                        irwr       = 1'b1;
                        pcwr       = 1'b1;
                        pcsrc      = PCS_ALU;
                        state_next = S_ID;
                    end
                end
                S_ID: begin
                    srcb = SRCB_IMM_SH2;
                    aluf = OP_ALU_ADD;
                    case (iclass)
                        CL_J:   begin pcwr = 1'b1; pcsrc = PCS_JUMP; end
                        CL_JAL: begin
                            pcwr  = 1'b1;
                            pcsrc = PCS_JUMP;
                            regwr = 1'b1;
                            link  = 1'b1;
                        end
                        CL_ILL: illegal = 1'b1;
                        default: state_next = S_EX;
                    endcase
                end
                S_EX: begin
                    srca = 1'b1;
                    aluf = dec_aluf;
                    case (iclass)
                        CL_R: begin srcb = SRCB_REG; state_next = S_WB; end
                        CL_ADDI, CL_ORI, CL_LUI: begin
                            srcb       = SRCB_IMM;
                            extop      = (iclass == CL_ADDI);
                            state_next = S_WB;
                        end
                        CL_LW, CL_SW: begin
                            srcb       = SRCB_IMM;
                            extop      = 1'b1;
                            state_next = S_MEM;
                        end
                        CL_BEQ: begin pcsrc = PCS_BRANCH; pcwr = bus.zero;  end
                        CL_BNE: begin pcsrc = PCS_BRANCH; pcwr = !bus.zero; end
                        default: state_next = S_IF;
                    endcase
                end
                S_MEM: begin
                    case (iclass)
                        CL_LW: begin
                            memrd      = 1'b1;
                            state_next = bus.mem_ready ? S_WB : S_MEM;
                        end
                        CL_SW: begin
                            memwr      = 1'b1;
                            state_next = bus.mem_ready ? S_IF : S_MEM;
                        end
                        default: state_next = S_IF;
                    endcase
                end
                S_WB: begin
                    regwr    = 1'b1;
                    regdst   = (iclass == CL_R);
                    memtoreg = (iclass == CL_LW);
                end
                default: state_next = S_IF;
            endcase
        end
    end

    assign bus.PCWr     = pcwr;
    assign bus.IRWr     = irwr;
    assign bus.MemRd    = memrd;
    assign bus.MemWr    = memwr;
    assign bus.RegWr    = regwr;
    assign bus.RegDst   = regdst;
    assign bus.MentoReg = memtoreg;
    assign bus.Extop    = extop;
    assign bus.ALUSrcA  = srca;
    assign bus.Link     = link;
    assign bus.ALUSrcB  = srcb;
    assign bus.PCSrc    = pcsrc;
    assign bus.aluf     = aluf;
    assign bus.state    = state_r;
    assign bus.illegal  = illegal;

endmodule
